alu_pipe: RTL
=============

Name: alu_pipe

Overview:
Parametrised, pipelined successor to the single-cycle combinational ALU. It keeps the legacy op encodings 000-100 and extends the op set with variable shifts, arithmetic shift, compares and saturating add/sub. It adds N/Z/C/V flags, a pass-through tag and valid/ready handshakes on both sides. It sits between an operand source (test sequencer, later the FIFO) and a result consumer, and supports full-throughput streaming with backpressure.

Parameters:
N, 16, operand/result width (>=4, power of 2)
STAGES, 2, pipeline register stages from accept to result (>=1)
TAG_W, 4, width of sideband tag carried alongside each operation

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts this cycle
in_a  in  N  operand A
in_b  in  N  operand B
in_op  in  4  opcode (see Behaviour)
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts this cycle
out_y  out  N  result
out_flags  out  4  {N,Z,C,V}
out_illegal  out  1  opcode was unassigned
out_tag  out  TAG_W  tag of this result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge, all stage valid bits clear. out_valid=0, out_y=0, out_flags=0, out_illegal=0, out_tag=0 after reset. in_ready=1 in the first cycle after reset.
- Transfers: input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
- Data stability: out_y, out_flags, out_illegal and out_tag hold stable while out_valid=1 and out_ready=0.
- Compute placement: the combinational result is computed from the accepted inputs and captured in stage 1. Stages 2..STAGES are plain registers.
- Latency: exactly STAGES cycles from input transfer to out_valid when the pipeline is not stalled.
- Elastic pipeline: stage k loads when stage k is empty or stage k+1 loads (the last stage "loads downstream" when out_ready=1).
  - in_ready = !v[1] || stage 2 loads; for STAGES=1, in_ready = !v[1] || out_ready.
  - Bubbles collapse.
  - Throughput is 1 op/cycle with out_ready held at 1.
  - No combinational path from in_valid to out_valid.
- Simultaneous accept and emit on a full pipeline is allowed; no item is lost or duplicated.
- Ordering: results emerge in acceptance order.
- Ops (SH = log2(N), s = b[SH-1:0]):
  - 0000 ADD: y=a+b. C=carry out. V=signed overflow.
  - 0001 SUB: y=a-b. C=1 iff a>=b unsigned. V=signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR: C=V=0.
  - 0101 SHL: y=a<<s. C=last bit shifted out, 0 if s=0. V=0.
  - 0110 SHR (logical): y=a>>s. C=last bit shifted out, 0 if s=0. V=0.
  - 0111 PASS: y=a. C=V=0.
  - 1000 SRA: arithmetic right shift by s. C as for SHR. V=0.
  - 1001 SLT: y=1 if a<b signed, else 0. C=V=0.
  - 1010 SLTU: y=1 if a<b unsigned, else 0. C=V=0.
  - 1011 ADDS: signed saturating add. Clamps to 2^(N-1)-1 or -2^(N-1). V=1 iff clamped. C=0.
  - 1100 SUBS: signed saturating subtract. Same clamping and V rule. C=0.
  - 1101-1111: y=a, flags=0, out_illegal=1.
- Flags: N=y[N-1] and Z=(y==0) for every op, including illegal ones.
- Shift range: upper bits of b above SH are ignored for shifts, so a shift count >= N is not possible.
- Reset mid-operation: all in-flight ops are discarded. No result emerges for them.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_SUBS), flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), op width constant 4.
- Sub-module alu_datapath (combinational, parameter N): a, b, op -> y, flags, illegal. It is instantiated once and feeds stage 1.
- alu_pipe owns the handshake and the stage registers.

Test Plan (N=16, STAGES=2 unless noted):
1. Reset then ADD a=0xFFFF, b=0x0001, tag=3 -> after 2 cycles: out_y=0x0000, flags N0 Z1 C1 V0, out_tag=3.
2. ADDS a=0x7FF0, b=0x0020 -> y=0x7FFF, V=1. SUBS a=0x8000, b=0x0001 -> y=0x8000, V=1. SUB a=0x0003, b=0x0005 -> y=0xFFFE, C=0, N=1.
3. SHL a=0x8001, b=0x0011 (s=1) -> y=0x0002, C=1. SRA a=0x8000, b=4 -> y=0xF800. SHR a=0x0001, b=0 -> y=0x0001, C=0.
4. Stream 8 back-to-back ops with out_ready=1 -> in_ready stays 1 and 8 results arrive on consecutive cycles, in order. Then hold out_ready=0 -> in_ready falls after exactly STAGES further accepts, and outputs stay stable.
5. Assert rst while 2 ops are in flight -> next cycle out_valid=0, outputs 0, in_ready=1. Those ops never appear.
6. Opcode 0xE with a=0x1234 -> y=0x1234, out_illegal=1, C=V=0. Repeat test 4 with STAGES=1 and STAGES=4 -> same ordering and throughput.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h5;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h6;
  localparam logic [OP_W-1:0] OP_PASS = 4'h7;
  localparam logic [OP_W-1:0] OP_SRA  = 4'h8;
  localparam logic [OP_W-1:0] OP_SLT  = 4'h9;
  localparam logic [OP_W-1:0] OP_SLTU = 4'hA;
  localparam logic [OP_W-1:0] OP_ADDS = 4'hB;
  localparam logic [OP_W-1:0] OP_SUBS = 4'hC;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: result, {N,Z,C,V} flags and illegal-opcode indication.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic [N-1:0]    y,
  output logic [3:0]      flags,
  output logic            illegal
);

  localparam int SH = $clog2(N);

  logic [SH-1:0] s;
  logic [N:0]    sum_ext;
  logic [N:0]    dif_ext;
  logic [N:0]    shl_ext;
  logic [N:0]    shr_ext;
  logic [N:0]    sra_ext;
  logic          add_ovf;
  logic          sub_ovf;
  logic [N-1:0]  sat;
  logic          c;
  logic          v;

  assign s       = b[SH-1:0];
  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} - {1'b0, b};
  assign add_ovf = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
  assign sub_ovf = (a[N-1] != b[N-1]) && (dif_ext[N-1] != a[N-1]);

  // The extra bit beside each shifted operand catches the last bit shifted out.
  assign shl_ext = {1'b0, a} << s;
  assign shr_ext = {a, 1'b0} >> s;
  assign sra_ext = $signed({a, 1'b0}) >>> s;

  // On overflow the true result always lies on the side of a's sign.
  assign sat = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    y       = a;
    c       = 1'b0;
    v       = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  begin y = sum_ext[N-1:0]; c = sum_ext[N]; v = add_ovf; end
      OP_SUB:  begin y = dif_ext[N-1:0]; c = !dif_ext[N]; v = sub_ovf; end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  begin y = shl_ext[N-1:0]; c = shl_ext[N]; end
      OP_SHR:  begin y = shr_ext[N:1]; c = shr_ext[0]; end
      OP_PASS: y = a;
      OP_SRA:  begin y = sra_ext[N:1]; c = sra_ext[0]; end
      OP_SLT:  y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: y = {{(N-1){1'b0}}, (a < b)};
      OP_ADDS: begin y = add_ovf ? sat : sum_ext[N-1:0]; v = add_ovf; end
      OP_SUBS: begin y = sub_ovf ? sat : dif_ext[N-1:0]; v = sub_ovf; end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = y[N-1];
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_pipe.sv
// Elastic valid/ready ALU pipeline: compute into stage 1, then STAGES-1 plain register stages.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_y,
  output logic [3:0]       out_flags,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [N-1:0]     y;
    logic [3:0]       flags;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [N-1:0]    dp_y;
  logic [3:0]      dp_flags;
  logic            dp_illegal;
  logic [STAGES:1] v;
  logic [STAGES:1] ld;
  logic            hole;
  stage_t          data [1:STAGES];

  alu_datapath #(.N(N)) u_datapath (
    .a       (in_a),
    .b       (in_b),
    .op      (in_op),
    .y       (dp_y),
    .flags   (dp_flags),
    .illegal (dp_illegal)
  );

  // A stage may load when it or any stage after it is empty, or the consumer takes the head.
  always_comb begin
    ld   = '0;
    hole = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      hole  = hole || !v[k];
      ld[k] = hole;
    end
  end

  assign in_ready = ld[1];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage samples its predecessor's old value.
    if (rst) begin
      v <= '0;
      // NOTE: the payload registers are reset too, because the outputs must read zero after reset.
      for (int k = 1; k <= STAGES; k++) data[k] <= '0;
    end else begin
      if (ld[1]) begin
        v[1] <= in_valid;
        if (in_valid) data[1] <= '{y: dp_y, flags: dp_flags, illegal: dp_illegal, tag: in_tag};
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) data[k] <= data[k-1];
        end
      end
    end
  end

  assign out_valid   = v[STAGES];
  assign out_y       = data[STAGES].y;
  assign out_flags   = data[STAGES].flags;
  assign out_illegal = data[STAGES].illegal;
  assign out_tag     = data[STAGES].tag;

endmodule
